// File: rtl/frame_cmd_pkg.sv
// Shared command-word layout, info codes and scheduler state encoding
// for the frame command scheduler.
package frame_cmd_pkg;

  typedef struct packed {
    logic [5:0]  sub_comp;
    logic [4:0]  child_comp;
    logic [3:0]  info;
    logic [2:0]  input_type;
    logic        pp_selc;
    logic [12:0] input_msg;
  } cmd_word_t;

  localparam logic [3:0]  INFO_WRITE = 4'b0001;
  localparam logic [3:0]  INFO_FLUSH = 4'b1111;
  localparam logic [31:0] CMD_IDLE   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DRAIN       = 2'd1,
    ST_WAIT_VBLANK = 2'd2,
    ST_FLUSH       = 2'd3
  } sched_state_t;

  function automatic logic is_write_cmd(input cmd_word_t w);
    return (w.info == INFO_WRITE);
  endfunction

  function automatic logic is_frame_marker(input cmd_word_t w);
    return (w.info == INFO_FLUSH);
  endfunction

  // Buffer-swap broadcast: only info and the ping/pong select are non-zero.
  function automatic cmd_word_t make_flush_word(input logic pp);
    cmd_word_t w;
    w         = cmd_word_t'(CMD_IDLE);
    w.info    = INFO_FLUSH;
    w.pp_selc = pp;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO: head word is read combinationally from the
// storage array, occupancy is reported as a level count.
module cmd_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (level_q == LW'(0));
  assign full_o    = (level_q == LW'(DEPTH));
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_cmd_scheduler.sv
// Queues Avalon command words and replays them to the display sub-components,
// holding frame markers until vertical blanking to swap the ping/pong buffer.
module frame_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 64,
  parameter int VBLANK_LINE = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [31:0]                   writedata,
  output logic                          waitrequest,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  output logic [31:0]                   cmd_out,
  output logic                          front_buf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import frame_cmd_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t  state_q;
  logic [31:0]   cmd_q;
  logic          front_buf_q;
  logic          flushed_q;

  cmd_word_t     wr_word_s;
  logic [31:0]   head_raw_s;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;
  logic          full_s;
  logic          in_vblank_s;
  logic          head_marker_s;
  logic          flush_go_s;
  logic [LW-1:0] level_s;
  logic          unused_hcount_s;

  assign unused_hcount_s = ^hcount;

  assign waitrequest   = full_s;
  assign fifo_level    = level_s;
  assign cmd_out       = cmd_q;
  assign front_buf     = front_buf_q;
  assign push_s        = chipselect && write && !waitrequest;
  assign in_vblank_s   = (vcount >= 10'(VBLANK_LINE));
  assign head_marker_s = !empty_s && is_frame_marker(cmd_word_t'(head_raw_s));
  assign flush_go_s    = (state_q == ST_WAIT_VBLANK) && in_vblank_s && !flushed_q;

  // Incoming words always target the buffer that is not on screen.
  always_comb begin
    wr_word_s         = cmd_word_t'(writedata);
    wr_word_s.pp_selc = ~front_buf_q;
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_s),
    .wdata_i (wr_word_s),
    .pop_i   (pop_s),
    .rdata_o (head_raw_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .level_o (level_s)
  );

  // A marker stays at the head until its flush, blocking everything behind it.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DRAIN: pop_s = !empty_s && !head_marker_s;
      ST_WAIT_VBLANK:    pop_s = flush_go_s;
      default:           pop_s = 1'b0;
    endcase
  end

  // Scheduler state machine with registered command, buffer index and flush flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_IDLE;
      front_buf_q <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      cmd_q <= CMD_IDLE;
      if (!in_vblank_s) begin
        flushed_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE, ST_DRAIN: begin
          if (empty_s) begin
            state_q <= ST_IDLE;
          end else if (head_marker_s) begin
            state_q <= ST_WAIT_VBLANK;
          end else begin
            state_q <= ST_DRAIN;
            cmd_q   <= head_raw_s;
          end
        end
        ST_WAIT_VBLANK: begin
          if (flush_go_s) begin
            state_q     <= ST_FLUSH;
            cmd_q       <= make_flush_word(~front_buf_q);
            front_buf_q <= ~front_buf_q;
            flushed_q   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state_q <= empty_s ? ST_IDLE : ST_DRAIN;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Scoreboard bench for frame_cmd_scheduler: an order-level queue model predicts
// the non-idle words on cmd_out; a monitor pops and compares them as they appear.
module tb_frame_cmd_scheduler;

  localparam int DEPTH = 64;
  localparam int VBL   = 480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_buf;
  logic [6:0]  fifo_level;

  frame_cmd_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .VBLANK_LINE (VBL)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .hcount      (hcount),
    .vcount      (vcount),
    .cmd_out     (cmd_out),
    .front_buf   (front_buf),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] w;
    bit          mk;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_q[$];
  bit          fb_m      = 1'b0;
  bit          flushed_m = 1'b0;
  bit          vb_m      = 1'b0;
  bit          mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] flush_word(input bit fb);
    return 32'h001E_0000 | (fb ? 32'h0000_0000 : 32'h0000_2000);
  endfunction

  // Emit everything the queue allows right now: words up to a marker, and a
  // marker itself only when in blanking and no flush has happened this blanking.
  task automatic m_settle();
    bit go;
    go = 1'b1;
    while (go && mq.size() > 0) begin
      if (!mq[0].mk) begin
        exp_q.push_back(mq[0].w);
        void'(mq.pop_front());
      end else if (vb_m && !flushed_m) begin
        exp_q.push_back(flush_word(fb_m));
        fb_m      = ~fb_m;
        flushed_m = 1'b1;
        void'(mq.pop_front());
      end else begin
        go = 1'b0;
      end
    end
  endtask

  task automatic m_push(input logic [31:0] w);
    ent_t e;
    e.w     = w;
    e.w[13] = ~fb_m;
    e.mk    = (w[20:17] == 4'hF);
    mq.push_back(e);
    m_settle();
  endtask

  task automatic m_vcount(input int v);
    vb_m = (v >= VBL);
    if (!vb_m) flushed_m = 1'b0;
    m_settle();
  endtask

  task automatic set_v(input int v);
    @(negedge clk);
    vcount = 10'(v);
    m_vcount(v);
  endtask

  task automatic wr(input logic [31:0] w);
    int b;
    b = 0;
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = w;
    hcount     = 10'($urandom);
    while (waitrequest === 1'b1 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("write_accept", {31'd0, waitrequest}, 32'd0);
    if (waitrequest === 1'b0) m_push(w);
  endtask

  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w        = $urandom;
    w[31:26] = 6'($urandom_range(1, 63));
    w[20:17] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  function automatic logic [31:0] rnd_marker();
    logic [31:0] w;
    w        = $urandom;
    w[20:17] = 4'hF;
    return w;
  endfunction

  function automatic bit mq_has_marker();
    foreach (mq[i]) if (mq[i].mk) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every non-idle word must be the next one the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && cmd_out !== 32'h0) begin
        if (exp_q.size() == 0) chk("unexpected_output", cmd_out, 32'h0);
        else                   chk("cmd_out_order", cmd_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w65;
    bit          old_fb;
    int          b;
    int          n;
    int          mk_at;

    rst_n = 1'b0; chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
    hcount = 10'd0; vcount = 10'd100;
    m_vcount(100);
    wait_cyc(3);
    chk("reset_cmd_out", cmd_out, 32'h0);
    chk("reset_front_buf", {31'd0, front_buf}, 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_waitrequest", {31'd0, waitrequest}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_cyc(2);

    // Single word latency: visible exactly two cycles after the write.
    wr(32'h3C02_4005);
    idle();
    chk("lat_n1_idle", cmd_out, 32'h0);
    @(negedge clk);
    chk("lat_n2_word", cmd_out, 32'h3C02_6005);
    @(negedge clk);
    chk("lat_n3_idle", cmd_out, 32'h0);
    wait_cyc(3);

    // Three words, marker, one word behind it.
    repeat (3) wr(rnd_word());
    wr(rnd_marker());
    wr(rnd_word());
    idle();
    wait_cyc(20);
    chk("pre_vblank_front", {31'd0, front_buf}, 32'd0);
    chk("pre_vblank_level", 32'(fifo_level), 32'd2);
    set_v(480);
    wait_cyc(20);
    chk("post_flush_front", {31'd0, front_buf}, 32'd1);
    chk("post_flush_level", 32'(fifo_level), 32'd0);

    // Two markers in one blanking interval: one flush now, one next frame.
    set_v(100);
    set_v(490);
    wr(rnd_marker());
    wr(rnd_marker());
    idle();
    wait_cyc(20);
    chk("two_mk_front_1", {31'd0, front_buf}, 32'd0);
    chk("two_mk_level_1", 32'(fifo_level), 32'd1);
    set_v(100);
    wait_cyc(5);
    set_v(480);
    wait_cyc(20);
    chk("two_mk_front_2", {31'd0, front_buf}, 32'd1);
    chk("two_mk_level_2", 32'(fifo_level), 32'd0);

    // Fill behind a waiting marker, then release it with blanking.
    set_v(100);
    wr(rnd_marker());
    repeat (DEPTH - 1) wr(rnd_word());
    idle();
    chk("full_level", 32'(fifo_level), 32'd64);
    chk("full_waitrequest", {31'd0, waitrequest}, 32'd1);
    w65 = rnd_word();
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; writedata = w65;
    repeat (4) begin
      @(negedge clk);
      chk("stall_waitrequest", {31'd0, waitrequest}, 32'd1);
    end
    chk("stall_level", 32'(fifo_level), 32'd64);
    old_fb = fb_m;
    vcount = 10'd480;
    m_vcount(480);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (waitrequest === 1'b1 && b < 20);
    chk("release_latency", 32'(b), 32'd1);
    chk("release_flush_word", cmd_out, flush_word(old_fb));
    m_push(w65);
    idle();
    wait_cyc(100);
    chk("fill_front", {31'd0, front_buf}, {31'd0, fb_m});
    chk("fill_level", 32'(fifo_level), 32'd0);

    // Reset while a marker waits with ten words behind it.
    set_v(100);
    wr(rnd_marker());
    repeat (10) wr(rnd_word());
    idle();
    wait_cyc(10);
    chk("pre_reset_level", 32'(fifo_level), 32'd11);
    chk("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_level", 32'(fifo_level), 32'd0);
    chk("async_reset_cmd", cmd_out, 32'h0);
    chk("async_reset_front", {31'd0, front_buf}, 32'd0);
    chk("async_reset_waitreq", {31'd0, waitrequest}, 32'd0);
    mq.delete();
    fb_m = 1'b0;
    flushed_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_v(490);
    wait_cyc(40);
    chk("post_reset_front", {31'd0, front_buf}, 32'd0);
    chk("post_reset_level", 32'(fifo_level), 32'd0);

    // Randomized frames: writes in active video, optional markers in blanking.
    for (int f = 0; f < 6; f++) begin
      set_v($urandom_range(0, VBL - 1));
      n     = $urandom_range(0, 20);
      mk_at = $urandom_range(0, 25);
      for (int i = 0; i < n; i++) begin
        if (mq.size() < 60) wr((i == mk_at) ? rnd_marker() : rnd_word());
      end
      idle();
      wait_cyc(90);
      chk("rnd_active_level", 32'(fifo_level), 32'(mq.size()));
      chk("rnd_active_front", {31'd0, front_buf}, {31'd0, fb_m});
      set_v($urandom_range(VBL, 600));
      if (!mq_has_marker() && $urandom_range(0, 1) == 1) begin
        wr(rnd_marker());
        idle();
      end
      wait_cyc(90);
      if ($urandom_range(0, 1) == 1) begin
        set_v($urandom_range(VBL, 600));
        wait_cyc(10);
      end
      chk("rnd_vblank_level", 32'(fifo_level), 32'(mq.size()));
      chk("rnd_vblank_front", {31'd0, front_buf}, {31'd0, fb_m});
    end

    wait_cyc(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
